// File: rtl/driver_monitor_pkg.sv
// Shared driver-monitor types: escalation FSM states, lamp codes and the output decode.
// Latency: none (types and a pure function). Backpressure: not applicable.
package driver_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARN   = 3'd1,
    ST_SNOOZE = 3'd2,
    ST_EMER   = 3'd3,
    ST_HOLD   = 3'd4,
    ST_CLEAR  = 3'd5
  } state_e;

  localparam logic [1:0] LAMP_OFF   = 2'b00;
  localparam logic [1:0] LAMP_AMBER = 2'b01;
  localparam logic [1:0] LAMP_RED   = 2'b11;

  typedef struct packed {
    logic       buzzer;
    logic [1:0] lamp;
    logic       hazard_on;
    logic       brake_req;
    logic       clear_req;
  } drive_t;

  // Moore decode of the driver/vehicle-facing outputs for a given state.
  function automatic drive_t decode_drive(input state_e st, input logic beep_hi);
    drive_t d;
    d = '0;
    case (st)
      ST_WARN: begin
        d.lamp   = LAMP_AMBER;
        d.buzzer = beep_hi;
      end
      ST_SNOOZE: d.lamp = LAMP_AMBER;
      ST_EMER, ST_HOLD: begin
        d.lamp      = LAMP_RED;
        d.buzzer    = 1'b1;
        d.hazard_on = 1'b1;
        d.brake_req = 1'b1;
      end
      ST_CLEAR: begin
        d.lamp      = LAMP_RED;
        d.clear_req = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alert_escalation_ctrl_if.sv
// Evaluator/driver/brake-facing signal bundle of the alert escalation controller.
// Latency: none (wiring only). Backpressure: level signals, no flow control.
interface alert_escalation_ctrl_if;
  logic       warning;
  logic       emergency;
  logic       driver_ack;
  logic       brake_ack;
  logic       buzzer;
  logic [1:0] lamp;
  logic       hazard_on;
  logic       brake_req;
  logic       clear_req;
  logic       brk_fault;

  modport master (
    output warning, emergency, driver_ack, brake_ack,
    input  buzzer, lamp, hazard_on, brake_req, clear_req, brk_fault
  );

  modport slave (
    input  warning, emergency, driver_ack, brake_ack,
    output buzzer, lamp, hazard_on, brake_req, clear_req, brk_fault
  );
endinterface

// File: rtl/alert_escalation_ctrl_cycle_timer.sv
// Saturating up-counter with clear and enable; done flags the last counted cycle before TC.
// Latency: count updates one cycle after enable. Backpressure: not applicable.
module cycle_timer #(
  parameter int unsigned TC = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);
  localparam int unsigned W = $clog2(TC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != W'(TC)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // High on the cycle whose enabled increment would reach TC.
  assign done_o = (cnt_q == W'(TC - 1));

endmodule

// File: rtl/alert_escalation_ctrl.sv
// Escalates evaluator warning/emergency into buzzer, lamp, braking handshake and re-arm pulse.
// Latency: outputs registered, 1 cycle after the sampling edge. Backpressure: none, level handshake.
module alert_escalation_ctrl
  import driver_monitor_pkg::*;
#(
  parameter int unsigned BEEP_ON    = 4,
  parameter int unsigned BEEP_OFF   = 4,
  parameter int unsigned WARN_TO    = 64,
  parameter int unsigned SNOOZE_CYC = 32,
  parameter int unsigned BRK_TO     = 16,
  parameter int unsigned ACK_HOLD   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  alert_escalation_ctrl_if.slave bus
);
  localparam int unsigned BP = BEEP_ON + BEEP_OFF;
  localparam int unsigned BW = $clog2(BP + 1);

  state_e        state_q, state_d;
  logic [BW-1:0] beep_q, beep_d;
  drive_t        drive_q, drive_d;
  logic          fault_q, fault_set;
  logic          entry;
  logic          warn_done, snz_done, brk_done, ack_done;

  always_comb begin
    state_d   = state_q;
    fault_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.emergency)    state_d = ST_EMER;
        else if (bus.warning) state_d = ST_WARN;
      end
      ST_WARN: begin
        if (bus.emergency)       state_d = ST_EMER;
        else if (!bus.warning)   state_d = ST_IDLE;
        else if (warn_done)      state_d = ST_EMER;
        else if (bus.driver_ack) state_d = ST_SNOOZE;
      end
      ST_SNOOZE: begin
        if (bus.emergency) state_d = ST_EMER;
        else if (snz_done) state_d = bus.warning ? ST_WARN : ST_IDLE;
      end
      ST_EMER: begin
        // A late ack on the timeout cycle still wins over the fault.
        if (bus.brake_ack) begin
          state_d = ST_HOLD;
        end else if (brk_done) begin
          state_d   = ST_HOLD;
          fault_set = 1'b1;
        end
      end
      ST_HOLD:  if (bus.driver_ack && ack_done) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    entry = (state_d != state_q);
    beep_d = '0;
    if (state_d == ST_WARN && !entry)
      beep_d = (beep_q == BW'(BP - 1)) ? '0 : beep_q + 1'b1;
    drive_d = decode_drive(state_d, beep_d < BW'(BEEP_ON));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      beep_q  <= '0;
      drive_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beep_q  <= beep_d;
      drive_q <= drive_d;
      if (fault_set) fault_q <= 1'b1;
    end
  end

  cycle_timer #(.TC(WARN_TO)) u_warn_tmr (
    .clk_i (clk_i), .rst_ni (rst_ni), .clr_i (entry),
    .en_i  (state_q == ST_WARN), .done_o (warn_done)
  );

  cycle_timer #(.TC(SNOOZE_CYC)) u_snz_tmr (
    .clk_i (clk_i), .rst_ni (rst_ni), .clr_i (entry),
    .en_i  (state_q == ST_SNOOZE), .done_o (snz_done)
  );

  cycle_timer #(.TC(BRK_TO)) u_brk_tmr (
    .clk_i (clk_i), .rst_ni (rst_ni), .clr_i (entry),
    .en_i  (state_q == ST_EMER), .done_o (brk_done)
  );

  // Any released cycle restarts the consecutive-acknowledge run.
  cycle_timer #(.TC(ACK_HOLD)) u_ack_tmr (
    .clk_i (clk_i), .rst_ni (rst_ni), .clr_i (entry || !bus.driver_ack),
    .en_i  (state_q == ST_HOLD && bus.driver_ack), .done_o (ack_done)
  );

  assign bus.buzzer    = drive_q.buzzer;
  assign bus.lamp      = drive_q.lamp;
  assign bus.hazard_on = drive_q.hazard_on;
  assign bus.brake_req = drive_q.brake_req;
  assign bus.clear_req = drive_q.clear_req;
  assign bus.brk_fault = fault_q;

endmodule

// File: doc/alert_escalation_ctrl.md
# alert_escalation_ctrl

Sequences the driver-facing and vehicle-facing response to the safety evaluator's `warning`/`emergency` flags. It drives a buzzer pattern and a dashboard lamp, escalates an ignored warning, and runs a level handshake requesting automatic braking. It holds the alarm until the driver gives a sustained acknowledge, then pulses `clear_req` to re-arm the upstream latched evaluator. Sits directly downstream of the safety evaluator in the driver-monitor top level.

## Interface
- `BEEP_ON`, 4: buzzer on-cycles per beep period in WARN
- `BEEP_OFF`, 4: buzzer off-cycles per beep period in WARN
- `WARN_TO`, 64: cycles of continuous WARN before forced escalation
- `SNOOZE_CYC`, 32: snooze duration after driver ack of a warning
- `BRK_TO`, 16: cycles allowed for `brake_ack` before fault
- `ACK_HOLD`, 8: consecutive `driver_ack` cycles needed to clear an emergency
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `warning`  in  1  level from safety evaluator
- `emergency`  in  1  level from safety evaluator (latched upstream)
- `driver_ack`  in  1  synchronised, debounced driver button level
- `brake_ack`  in  1  brake controller acknowledge level
- `buzzer`  out  1  buzzer drive
- `lamp`  out  2  00 off, 01 amber, 11 red
- `hazard_on`  out  1  hazard lights request
- `brake_req`  out  1  automatic braking request level
- `clear_req`  out  1  one-cycle re-arm pulse to safety evaluator
- `brk_fault`  out  1  sticky: brake controller failed to acknowledge

## Operation
- States: IDLE, WARN, SNOOZE, EMER, HOLD, CLEAR.
- IDLE: all outputs 0 except sticky `brk_fault`. `emergency` -> EMER; else `warning` -> WARN.
- WARN: lamp=01; buzzer alternates BEEP_ON high / BEEP_OFF low, starting high on the entry cycle; warn timer counts up. Priority: `emergency` -> EMER; `warning`=0 -> IDLE; timer reaches WARN_TO -> EMER; `driver_ack` -> SNOOZE.
- SNOOZE: lamp=01, buzzer=0, snooze timer counts. `emergency` -> EMER; at expiry -> WARN if `warning`, else IDLE.
- EMER: lamp=11, buzzer=1, hazard_on=1, brake_req=1; brake timer counts. `brake_ack` -> HOLD. At BRK_TO without ack: set `brk_fault`, -> HOLD.
- HOLD: same outputs as EMER; `brake_req` stays high. The ack counter increments while `driver_ack`=1 and resets to 0 when it is 0. When the count reaches ACK_HOLD -> CLEAR.
- CLEAR: lamp=11, buzzer=0, brake_req=0, clear_req=1 for exactly one cycle; -> IDLE unconditionally.
- All timers reset to 0 on every state entry.
- `brake_ack` outside EMER/HOLD is ignored.
- `driver_ack` outside WARN/HOLD is ignored.
- If `emergency` is still high in IDLE, the FSM re-enters EMER next cycle.
- `brk_fault` clears only on reset.

## Timing
- Reset: state=IDLE, counters=0, all outputs 0 including `brk_fault`. Reset asserted mid-handshake drops `brake_req` immediately (asynchronous).
- Outputs are Moore-decoded from registered state and beep counter. An input sampled at edge N changes outputs after edge N (1-cycle latency).
- Beep period is BEEP_ON+BEEP_OFF cycles and wraps indefinitely while in WARN.
- WARN escalation occurs on the edge where the warn timer equals WARN_TO−1, i.e. WARN_TO cycles after entry.
- Brake fault asserts BRK_TO cycles after EMER entry if `brake_ack` never seen. If `brake_ack` and timeout coincide, the ack wins and no fault is set.
- Simultaneous events in WARN: emergency > warning drop > timeout > driver_ack.
- Counter widths are `$clog2(param+1)`. Counters saturate and never wrap.

## Structure
- Shared package `driver_monitor_pkg`: state encoding localparams and lamp codes (LAMP_OFF, LAMP_AMBER, LAMP_RED).
- One sub-module, `cycle_timer`: up-counter with clear, enable, parameterised terminal count, `done` flag. Instantiated for warn, snooze, brake and ack timing, or shared with a single counter.

## Test plan
Test values: BEEP_ON=2, BEEP_OFF=2, WARN_TO=10, SNOOZE_CYC=5, BRK_TO=6, ACK_HOLD=3.
- Reset mid-EMER with `brake_req`=1: reset low -> all outputs 0 immediately; IDLE after release.
- `warning`=1 held for 10 cycles: lamp=01, buzzer 1,1,0,0,1,1,0,0,1,1; cycle 11 lamp=11, `brake_req`=1.
- In WARN, pulse `driver_ack` with `warning` held: buzzer=0 for 5 cycles, then WARN with beep restarting high.
- `emergency`=1, `brake_ack` at 3rd EMER cycle: HOLD reached with `brk_fault`=0. `driver_ack` 1,1,0,1,1,1 -> `clear_req` pulses once after the 3rd consecutive high; then IDLE.
- `emergency`=1, `brake_ack` never asserted: `brk_fault`=1 after 6 cycles and stays 1 through CLEAR and IDLE until reset.
- Same cycle in WARN: `emergency`=1 and `driver_ack`=1 -> EMER, not SNOOZE.
